// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard controller: writeback-source selects and MDU tracker states.
package hazard_pkg;

   localparam logic [1:0] WD_SEL_FROM_ALU  = 2'd0;
   localparam logic [1:0] WD_SEL_FROM_DRAM = 2'd1;
   localparam logic [1:0] WD_SEL_FROM_PC4  = 2'd2;
   localparam logic [1:0] WD_SEL_FROM_IMM  = 2'd3;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } mdu_state_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-writeback bit per architectural register for long-latency MDU results.
module reg_scoreboard #(
   parameter int NREG = 32,
   parameter int RAW  = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            set_i,
   input  logic [RAW-1:0]  set_idx_i,
   input  logic            clr_i,
   input  logic [RAW-1:0]  clr_idx_i,
   output logic [NREG-1:0] pending_o
);

   logic [NREG-1:0] pending_q;
   logic [NREG-1:0] pending_d;

   // Clear is applied before set so a retiring op and a new issue to the same register leaves it pending.
   always_comb begin
      pending_d = pending_q;
      if (clr_i) pending_d[clr_idx_i] = 1'b0;
      if (set_i && (set_idx_i != '0)) pending_d[set_idx_i] = 1'b1;
      pending_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pending_q <= '0;
      else        pending_q <= pending_d;
   end

   assign pending_o = pending_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: RAW forwarding, load-use / MDU stalls, branch-mispredict flushes and perf counters.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int NREG  = 32,
   parameter int CNT_W = 32,
   parameter int RAW   = $clog2(NREG)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             rs1_used_ID,
   input  logic             rs2_used_ID,
   input  logic [RAW-1:0]   rR1_ID,
   input  logic [RAW-1:0]   rR2_ID,
   input  logic             mdu_op_ID,
   input  logic [RAW-1:0]   wR_EX,
   input  logic [RAW-1:0]   wR_MEM,
   input  logic [RAW-1:0]   wR_WB,
   input  logic             rf_we_EX,
   input  logic             rf_we_MEM,
   input  logic             rf_we_WB,
   input  logic [XLEN-1:0]  rf_wd_EX,
   input  logic [XLEN-1:0]  rf_wd_MEM,
   input  logic [XLEN-1:0]  rf_wd_WB,
   input  logic [1:0]       wd_sel_EX,
   input  logic [1:0]       wd_sel_MEM,
   input  logic             mdu_issue_EX,
   input  logic             mdu_done,
   input  logic [RAW-1:0]   mdu_wR,
   input  logic [XLEN-1:0]  mdu_wd,
   input  logic             is_branch_EX,
   input  logic             branch_pred_EX,
   input  logic             branch_taken_EX,
   output logic             keep_pc,
   output logic             stall_IF_ID,
   output logic             flush_IF_ID,
   output logic             flush_ID_EX,
   output logic             fwd_rD1e_EX,
   output logic             fwd_rD2e_EX,
   output logic [XLEN-1:0]  fwd_rD1_EX,
   output logic [XLEN-1:0]  fwd_rD2_EX,
   output logic             mdu_busy,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   // MDU protocol: mdu_issue_EX is a one-cycle launch strobe; mdu_done is a one-cycle result strobe
   // that is only honoured while BUSY. There is no back-pressure in either direction.
   mdu_state_t       state_q;
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] flush_cnt_q;
   logic [NREG-1:0]  pending;

   logic [RAW-1:0]   rr     [2];
   logic             used   [2];
   logic             m_ex   [2];
   logic             m_mem  [2];
   logic             m_wb   [2];
   logic             m_mdu  [2];
   logic             fwd_e  [2];
   logic [XLEN-1:0]  fwd_d  [2];
   logic             ex_load, mem_load, done_eff, hazard, mispredict, sb_set;

   always_comb begin
      rr[0]    = rR1_ID;
      rr[1]    = rR2_ID;
      used[0]  = rs1_used_ID;
      used[1]  = rs2_used_ID;
      ex_load  = (wd_sel_EX == WD_SEL_FROM_DRAM);
      mem_load = (wd_sel_MEM == WD_SEL_FROM_DRAM);
      done_eff = mdu_done && (state_q == BUSY);
      hazard   = mdu_op_ID && (((state_q == BUSY) && !mdu_done) || mdu_issue_EX);
      for (int n = 0; n < 2; n++) begin
         m_ex[n]  = used[n] && rf_we_EX  && (wR_EX  == rr[n]) && (wR_EX  != '0);
         m_mem[n] = used[n] && rf_we_MEM && (wR_MEM == rr[n]) && (wR_MEM != '0);
         m_wb[n]  = used[n] && rf_we_WB  && (wR_WB  == rr[n]) && (wR_WB  != '0);
         m_mdu[n] = mdu_done && (mdu_wR == rr[n]) && (mdu_wR != '0);
         // A matching EX/MEM value that is not yet available falls through to older stages; the stall covers it.
         fwd_e[n] = 1'b1;
         if (m_ex[n] && !mdu_issue_EX && !ex_load) fwd_d[n] = rf_wd_EX;
         else if (m_mem[n] && !mem_load)           fwd_d[n] = rf_wd_MEM;
         else if (m_wb[n])                         fwd_d[n] = rf_wd_WB;
         else if (m_mdu[n])                        fwd_d[n] = mdu_wd;
         else begin
            fwd_d[n] = '0;
            fwd_e[n] = 1'b0;
         end
         if ((m_ex[n] && (ex_load || mdu_issue_EX)) || (m_mem[n] && mem_load)) hazard = 1'b1;
         if (used[n] && pending[rr[n]] && !(done_eff && (mdu_wR == rr[n])))    hazard = 1'b1;
      end
   end

   assign mispredict  = is_branch_EX && (branch_pred_EX != branch_taken_EX);
   assign flush_IF_ID = mispredict;
   assign flush_ID_EX = mispredict || hazard;
   assign keep_pc     = hazard && !mispredict;
   assign stall_IF_ID = hazard && !mispredict;
   assign fwd_rD1e_EX = fwd_e[0];
   assign fwd_rD2e_EX = fwd_e[1];
   assign fwd_rD1_EX  = fwd_d[0];
   assign fwd_rD2_EX  = fwd_d[1];
   assign sb_set      = mdu_issue_EX && rf_we_EX && (wR_EX != '0);

   reg_scoreboard #(
      .NREG (NREG),
      .RAW  (RAW)
   ) u_sb (
      .clk       (clk),
      .rst_n     (rst_n),
      .set_i     (sb_set),
      .set_idx_i (wR_EX),
      .clr_i     (done_eff),
      .clr_idx_i (mdu_wR),
      .pending_o (pending)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         case (state_q)
            IDLE:    if (mdu_issue_EX) state_q <= BUSY;
            BUSY:    if (mdu_done && !mdu_issue_EX) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
         if (keep_pc && (stall_cnt_q != '1))     stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         if (flush_IF_ID && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
   end

   assign mdu_busy  = (state_q == BUSY);
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomised and directed bench for hazard_ctrl against a rule-level reference model.
module tb_hazard_ctrl;
   import hazard_pkg::*;

   localparam int XLEN  = 32;
   localparam int NREG  = 32;
   localparam int CNT_W = 4;
   localparam int RAW   = 5;
   localparam int CMAX  = 15;

   typedef struct packed {
      logic            rst_n;
      logic            use1, use2;
      logic [RAW-1:0]  rr1, rr2;
      logic            mdu_op;
      logic [RAW-1:0]  wr_ex, wr_mem, wr_wb;
      logic            we_ex, we_mem, we_wb;
      logic [XLEN-1:0] wd_ex, wd_mem, wd_wb;
      logic [1:0]      sel_ex, sel_mem;
      logic            issue, done;
      logic [RAW-1:0]  mdu_wr;
      logic [XLEN-1:0] mdu_wd;
      logic            is_br, pred, taken;
   } in_t;

   typedef struct packed {
      logic             keep_pc, stall, fl_if, fl_ex, fe1, fe2;
      logic [XLEN-1:0]  f1, f2;
      logic             busy;
      logic [CNT_W-1:0] scnt, fcnt;
   } out_t;

   logic clk = 1'b0;
   logic rst_n;
   logic rs1_used_ID, rs2_used_ID, mdu_op_ID;
   logic [RAW-1:0] rR1_ID, rR2_ID, wR_EX, wR_MEM, wR_WB, mdu_wR;
   logic rf_we_EX, rf_we_MEM, rf_we_WB;
   logic [XLEN-1:0] rf_wd_EX, rf_wd_MEM, rf_wd_WB, mdu_wd;
   logic [1:0] wd_sel_EX, wd_sel_MEM;
   logic mdu_issue_EX, mdu_done, is_branch_EX, branch_pred_EX, branch_taken_EX;
   logic keep_pc, stall_IF_ID, flush_IF_ID, flush_ID_EX, fwd_rD1e_EX, fwd_rD2e_EX, mdu_busy;
   logic [XLEN-1:0] fwd_rD1_EX, fwd_rD2_EX;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   out_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   bit   m_pend [NREG];
   bit   m_busy;
   int   m_scnt, m_fcnt;

   hazard_ctrl #(.XLEN(XLEN), .NREG(NREG), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .rs1_used_ID(rs1_used_ID), .rs2_used_ID(rs2_used_ID), .rR1_ID(rR1_ID), .rR2_ID(rR2_ID),
      .mdu_op_ID(mdu_op_ID),
      .wR_EX(wR_EX), .wR_MEM(wR_MEM), .wR_WB(wR_WB),
      .rf_we_EX(rf_we_EX), .rf_we_MEM(rf_we_MEM), .rf_we_WB(rf_we_WB),
      .rf_wd_EX(rf_wd_EX), .rf_wd_MEM(rf_wd_MEM), .rf_wd_WB(rf_wd_WB),
      .wd_sel_EX(wd_sel_EX), .wd_sel_MEM(wd_sel_MEM),
      .mdu_issue_EX(mdu_issue_EX), .mdu_done(mdu_done), .mdu_wR(mdu_wR), .mdu_wd(mdu_wd),
      .is_branch_EX(is_branch_EX), .branch_pred_EX(branch_pred_EX), .branch_taken_EX(branch_taken_EX),
      .keep_pc(keep_pc), .stall_IF_ID(stall_IF_ID), .flush_IF_ID(flush_IF_ID), .flush_ID_EX(flush_ID_EX),
      .fwd_rD1e_EX(fwd_rD1e_EX), .fwd_rD2e_EX(fwd_rD2e_EX), .fwd_rD1_EX(fwd_rD1_EX), .fwd_rD2_EX(fwd_rD2_EX),
      .mdu_busy(mdu_busy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic out_t predict(input in_t v);
      out_t            o;
      bit              haz;
      logic [RAW-1:0]  src [2];
      bit              use_ [2];
      logic [RAW-1:0]  st_wr [3];
      bit              st_we [3];
      logic [XLEN-1:0] st_wd [3];
      bit              st_ok [3];
      bit              st_blk [3];
      bit              found;
      logic [XLEN-1:0] val;
      src[0] = v.rr1;  src[1] = v.rr2;
      use_[0] = v.use1; use_[1] = v.use2;
      st_wr[0] = v.wr_ex;  st_we[0] = v.we_ex;  st_wd[0] = v.wd_ex;
      st_wr[1] = v.wr_mem; st_we[1] = v.we_mem; st_wd[1] = v.wd_mem;
      st_wr[2] = v.wr_wb;  st_we[2] = v.we_wb;  st_wd[2] = v.wd_wb;
      st_blk[0] = (v.sel_ex == WD_SEL_FROM_DRAM) || v.issue;
      st_blk[1] = (v.sel_mem == WD_SEL_FROM_DRAM);
      st_blk[2] = 1'b0;
      for (int s = 0; s < 3; s++) st_ok[s] = !st_blk[s];
      o = '0;
      haz = v.mdu_op && ((m_busy && !v.done) || v.issue);
      for (int n = 0; n < 2; n++) begin
         found = 0;
         val   = '0;
         for (int s = 0; s < 3; s++) begin
            if (use_[n] && st_we[s] && st_wr[s] == src[n] && st_wr[s] != 0) begin
               if (st_blk[s]) haz = 1;
               if (!found && st_ok[s]) begin found = 1; val = st_wd[s]; end
            end
         end
         if (!found && v.done && v.mdu_wr == src[n] && v.mdu_wr != 0) begin found = 1; val = v.mdu_wd; end
         if (use_[n] && m_pend[src[n]] && !(m_busy && v.done && v.mdu_wr == src[n])) haz = 1;
         if (n == 0) begin o.fe1 = found; o.f1 = val; end
         else        begin o.fe2 = found; o.f2 = val; end
      end
      o.fl_if   = v.is_br && (v.pred != v.taken);
      o.fl_ex   = o.fl_if || haz;
      o.keep_pc = haz && !o.fl_if;
      o.stall   = o.keep_pc;
      o.busy    = m_busy;
      o.scnt    = CNT_W'(m_scnt);
      o.fcnt    = CNT_W'(m_fcnt);
      return o;
   endfunction

   task automatic model_reset();
      for (int r = 0; r < NREG; r++) m_pend[r] = 0;
      m_busy = 0;
      m_scnt = 0;
      m_fcnt = 0;
   endtask

   task automatic model_step(input in_t v, input out_t o);
      if (o.keep_pc && m_scnt < CMAX) m_scnt++;
      if (o.fl_if && m_fcnt < CMAX) m_fcnt++;
      if (m_busy && v.done) m_pend[v.mdu_wr] = 0;
      if (v.issue && v.we_ex && v.wr_ex != 0) m_pend[v.wr_ex] = 1;
      m_busy = v.issue || (m_busy && !v.done);
   endtask

   // ---------------- driver ----------------
   task automatic drive(input in_t v);
      out_t o;
      @(posedge clk);
      #2;
      rst_n = v.rst_n;
      rs1_used_ID = v.use1; rs2_used_ID = v.use2; rR1_ID = v.rr1; rR2_ID = v.rr2;
      mdu_op_ID = v.mdu_op;
      wR_EX = v.wr_ex; wR_MEM = v.wr_mem; wR_WB = v.wr_wb;
      rf_we_EX = v.we_ex; rf_we_MEM = v.we_mem; rf_we_WB = v.we_wb;
      rf_wd_EX = v.wd_ex; rf_wd_MEM = v.wd_mem; rf_wd_WB = v.wd_wb;
      wd_sel_EX = v.sel_ex; wd_sel_MEM = v.sel_mem;
      mdu_issue_EX = v.issue; mdu_done = v.done; mdu_wR = v.mdu_wr; mdu_wd = v.mdu_wd;
      is_branch_EX = v.is_br; branch_pred_EX = v.pred; branch_taken_EX = v.taken;
      if (!v.rst_n) model_reset();
      o = predict(v);
      exp_q.push_back(o);
      if (v.rst_n) model_step(v, o);
   endtask

   function automatic in_t idle_in();
      in_t v;
      v = '0;
      v.rst_n = 1'b1;
      return v;
   endfunction

   function automatic in_t rand_in();
      in_t v;
      v.rst_n   = ($urandom_range(0, 59) != 0);
      v.use1    = $urandom_range(0, 1);   v.use2   = $urandom_range(0, 1);
      v.rr1     = RAW'($urandom_range(0, 7)); v.rr2 = RAW'($urandom_range(0, 7));
      v.mdu_op  = ($urandom_range(0, 3) == 0);
      v.wr_ex   = RAW'($urandom_range(0, 7)); v.wr_mem = RAW'($urandom_range(0, 7));
      v.wr_wb   = RAW'($urandom_range(0, 7));
      v.we_ex   = $urandom_range(0, 1);   v.we_mem = $urandom_range(0, 1); v.we_wb = $urandom_range(0, 1);
      v.wd_ex   = $urandom;               v.wd_mem = $urandom;             v.wd_wb = $urandom;
      v.sel_ex  = 2'($urandom_range(0, 3)); v.sel_mem = 2'($urandom_range(0, 3));
      v.issue   = ($urandom_range(0, 5) == 0);
      v.done    = ($urandom_range(0, 4) == 0);
      v.mdu_wr  = RAW'($urandom_range(0, 7));
      v.mdu_wd  = $urandom;
      v.is_br   = ($urandom_range(0, 2) == 0);
      v.pred    = $urandom_range(0, 1);   v.taken  = $urandom_range(0, 1);
      return v;
   endfunction

   // ---------------- scoreboard / monitor ----------------
   task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      out_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("keep_pc",     XLEN'(keep_pc),     XLEN'(e.keep_pc));
         check("stall_IF_ID", XLEN'(stall_IF_ID), XLEN'(e.stall));
         check("flush_IF_ID", XLEN'(flush_IF_ID), XLEN'(e.fl_if));
         check("flush_ID_EX", XLEN'(flush_ID_EX), XLEN'(e.fl_ex));
         check("fwd_rD1e",    XLEN'(fwd_rD1e_EX), XLEN'(e.fe1));
         check("fwd_rD2e",    XLEN'(fwd_rD2e_EX), XLEN'(e.fe2));
         check("fwd_rD1",     fwd_rD1_EX,         e.f1);
         check("fwd_rD2",     fwd_rD2_EX,         e.f2);
         check("mdu_busy",    XLEN'(mdu_busy),    XLEN'(e.busy));
         check("stall_cnt",   XLEN'(stall_cnt),   XLEN'(e.scnt));
         check("flush_cnt",   XLEN'(flush_cnt),   XLEN'(e.fcnt));
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      in_t v;
      rst_n = 1'b0;
      v = idle_in(); v.rst_n = 1'b0;
      drive(v);
      #1 check("reset_busy", XLEN'(mdu_busy), '0);
      check("reset_stall_cnt", XLEN'(stall_cnt), '0);

      // EX beats MEM for the same register
      v = idle_in();
      v.wr_ex = 5; v.we_ex = 1; v.wd_ex = 32'h11; v.sel_ex = WD_SEL_FROM_ALU;
      v.wr_mem = 5; v.we_mem = 1; v.wd_mem = 32'h22;
      v.rr1 = 5; v.use1 = 1;
      drive(v);
      #1 check("dir_fwd_ex", fwd_rD1_EX, 32'h11);
      check("dir_fwd_ex_nostall", XLEN'(keep_pc), '0);

      // load-use: stall in EX and MEM, forward from WB on the third cycle
      v = idle_in(); v.rr2 = 7; v.use2 = 1;
      v.wr_ex = 7; v.we_ex = 1; v.sel_ex = WD_SEL_FROM_DRAM;
      drive(v);
      #1 check("dir_lu_stall1", XLEN'(keep_pc), 1);
      v.we_ex = 0; v.wr_ex = 0; v.sel_ex = WD_SEL_FROM_ALU;
      v.wr_mem = 7; v.we_mem = 1; v.sel_mem = WD_SEL_FROM_DRAM;
      drive(v);
      #1 check("dir_lu_stall2", XLEN'(flush_ID_EX), 1);
      v.we_mem = 0; v.wr_mem = 0; v.sel_mem = WD_SEL_FROM_ALU;
      v.wr_wb = 7; v.we_wb = 1; v.wd_wb = 32'h77;
      drive(v);
      #1 check("dir_lu_wb_fwd", fwd_rD2_EX, 32'h77);
      check("dir_lu_release", XLEN'(keep_pc), '0);

      // MDU issue on x9, result after 8 cycles
      v = idle_in(); v.rst_n = 1'b0; drive(v);
      v = idle_in(); v.rr1 = 9; v.use1 = 1;
      v.issue = 1; v.we_ex = 1; v.wr_ex = 9;
      drive(v);
      v = idle_in(); v.rr1 = 9; v.use1 = 1;
      for (int i = 0; i < 7; i++) drive(v);
      v.done = 1; v.mdu_wr = 9; v.mdu_wd = 32'hABCD;
      drive(v);
      #1 check("dir_mdu_stall_cnt", XLEN'(stall_cnt), 8);
      check("dir_mdu_fwd", fwd_rD1_EX, 32'hABCD);
      check("dir_mdu_nostall", XLEN'(keep_pc), '0);

      // load-use and mispredict in the same cycle
      v = idle_in(); v.rst_n = 1'b0; drive(v);
      v = idle_in(); v.rr2 = 7; v.use2 = 1;
      v.wr_ex = 7; v.we_ex = 1; v.sel_ex = WD_SEL_FROM_DRAM;
      v.is_br = 1; v.pred = 0; v.taken = 1;
      drive(v);
      #1 check("dir_mp_keep_pc", XLEN'(keep_pc), '0);
      check("dir_mp_flush_if", XLEN'(flush_IF_ID), 1);
      drive(idle_in());
      #1 check("dir_mp_flush_cnt", XLEN'(flush_cnt), 1);

      // reset mid-MDU drops the pending tag; later done is ignored
      v = idle_in(); v.issue = 1; v.we_ex = 1; v.wr_ex = 3;
      drive(v);
      drive(idle_in());
      v = idle_in(); v.rst_n = 1'b0; drive(v);
      #1 check("dir_rst_busy", XLEN'(mdu_busy), '0);
      v = idle_in(); v.rr1 = 3; v.use1 = 1; v.done = 1; v.mdu_wr = 3;
      drive(v);
      v.done = 0;
      drive(v);
      #1 check("dir_rst_nostall", XLEN'(keep_pc), '0);

      // stall counter saturation
      v = idle_in(); v.rst_n = 1'b0; drive(v);
      v = idle_in(); v.rr1 = 4; v.use1 = 1;
      v.wr_ex = 4; v.we_ex = 1; v.sel_ex = WD_SEL_FROM_DRAM;
      for (int i = 0; i < 20; i++) drive(v);
      drive(idle_in());
      #1 check("dir_stall_sat", XLEN'(stall_cnt), 15);

      // randomised traffic
      for (int i = 0; i < 800; i++) drive(rand_in());

      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d entries left expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameters (name, default, meaning): XLEN, 32, datapath width; NREG, 32, architectural registers; CNT_W, 32, perf-counter width; RAW = $clog2(NREG), derived register-address width.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low. Ports: clk  in  1  rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-003 rs1_used_ID, rs2_used_ID  in  1  ID source register is read; rR1_ID, rR2_ID  in  RAW  ID source addresses.
REQ-004 mdu_op_ID  in  1  ID holds a multi-cycle mul/div op.
REQ-005 wR_EX/wR_MEM/wR_WB  in  RAW; rf_we_EX/MEM/WB  in  1; rf_wd_EX/MEM/WB  in  XLEN; wd_sel_EX, wd_sel_MEM  in  2  writeback source.
REQ-006 mdu_issue_EX  in  1  EX instruction launches the MDU; mdu_done  in  1  MDU result valid this cycle; mdu_wR  in  RAW; mdu_wd  in  XLEN.
REQ-007 is_branch_EX, branch_pred_EX, branch_taken_EX  in  1  EX control-transfer, predicted and resolved direction.
REQ-008 keep_pc, stall_IF_ID, flush_IF_ID, flush_ID_EX  out  1  pipeline control.
REQ-009 fwd_rD1e_EX, fwd_rD2e_EX  out  1; fwd_rD1_EX, fwd_rD2_EX  out  XLEN  forwarding enable/data.
REQ-010 mdu_busy  out  1; stall_cnt, flush_cnt  out  CNT_W  perf counters.

Function
REQ-011 RAW match per stage S (EX/MEM/WB) and source n SHALL be: wR_S == rRn_ID, rf_we_S, rsn_used_ID, wR_S != 0.
REQ-012 Forward data priority SHALL be: EX match (not mdu_issue_EX, not DRAM load) > MEM match (not DRAM load) > WB match > mdu_done with mdu_wR match (nonzero); else 0; enable = any selectable source.
REQ-013 Scoreboard: NREG pending bits; bit wR_EX SHALL set at clock edge when mdu_issue_EX && rf_we_EX && wR_EX != 0; bit mdu_wR SHALL clear at edge when mdu_done; bit 0 never set.
REQ-014 MDU FSM states IDLE, BUSY: IDLE->BUSY on mdu_issue_EX; BUSY->IDLE on mdu_done; mdu_done in IDLE SHALL be ignored (no scoreboard change); mdu_busy = (state == BUSY).
REQ-015 hazard SHALL be asserted for: EX DRAM load RAW match; MEM DRAM load RAW match; EX mdu_issue_EX RAW match; used source pending in scoreboard and not cleared by mdu_done this cycle; mdu_op_ID while (BUSY && !mdu_done) or mdu_issue_EX.
REQ-016 mispredict = is_branch_EX && (branch_pred_EX != branch_taken_EX); flush_IF_ID = mispredict; flush_ID_EX = mispredict || hazard.
REQ-017 keep_pc = stall_IF_ID = hazard && !mispredict (flush dominates stall).
REQ-018 All control and forwarding outputs SHALL be combinational, zero-latency from inputs and current state.
REQ-019 stall_cnt SHALL increment each cycle keep_pc = 1; flush_cnt each cycle flush_IF_ID = 1; both saturate at all-ones.
REQ-020 Issue and done on the same edge (BUSY, done, new issue) SHALL clear old bit, set new bit and stay BUSY.

Reset
REQ-021 rst_n low SHALL immediately clear all scoreboard bits, force IDLE, zero stall_cnt and flush_cnt; mdu_busy = 0.
REQ-022 Reset mid-MDU-operation SHALL drop the pending tag; a later mdu_done in IDLE is ignored per REQ-014.

Structure
REQ-023 Package hazard_pkg SHALL hold wd_sel encodings (incl. WD_SEL_FROM_DRAM) and mdu_state_t {IDLE, BUSY}.
REQ-024 Scoreboard SHALL be sub-module reg_scoreboard (set/clear ports, NREG parameter, pending vector output).

Verification
REQ-025 EX: wR_EX=5, rf_we_EX=1, rf_wd_EX=0x11; MEM: wR_MEM=5, rf_wd_MEM=0x22; ID rR1=5 used -> fwd_rD1_EX=0x11, enable=1, no stall.
REQ-026 EX load wR=7, ID rR2=7 used -> keep_pc=stall_IF_ID=flush_ID_EX=1 for 2 cycles as load moves EX->MEM; third cycle forwards rf_wd_WB.
REQ-027 MDU issue wR=9, done after 8 cycles with mdu_wd=0xABCD; ID reads x9 -> stall 8 cycles, stall_cnt=8; done cycle fwd=0xABCD, no stall.
REQ-028 Load-use hazard plus mispredict same cycle -> flush_IF_ID=flush_ID_EX=1, keep_pc=0, flush_cnt +1.
REQ-029 MDU BUSY on x3, rst_n pulsed low -> mdu_busy=0, pending cleared; later mdu_done ignored; ID read of x3 not stalled.
REQ-030 CNT_W=4, hold hazard 20 cycles -> stall_cnt saturates at 15.
